// File: rtl/lfsr_pkg.sv
// ============================================================================
// Module      : lfsr_pkg
// Description : Mode encoding and default maximal-length tap masks shared by
//               the LFSR / PRBS generator slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lfsr_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD     = 2'b00,
        MODE_SHIFT    = 2'b01,
        MODE_RUN      = 2'b10,
        MODE_SCRAMBLE = 2'b11
    } lfsr_mode_e;

    // Fibonacci taps for a left-shifting register: bit i feeds the XOR
    localparam logic [3:0]  TAPS_4  = 4'hC;
    localparam logic [6:0]  TAPS_7  = 7'h60;
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [14:0] TAPS_15 = 15'h6000;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [22:0] TAPS_23 = 23'h42_0000;
    localparam logic [30:0] TAPS_31 = 31'h4800_0000;

endpackage

`default_nettype wire

// File: rtl/lfsr_prbs_gen_if.sv
// ============================================================================
// Module      : lfsr_prbs_gen_if
// Description : Control and observation bundle between the CSR block and the
//               LFSR / PRBS generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lfsr_prbs_gen_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic             si;
    logic             seed_ld;
    logic [WIDTH-1:0] seed;
    logic             q;
    logic [WIDTH-1:0] state;
    logic             lockup;
    logic             wrap;
    logic [WIDTH-1:0] period;

    modport master (
        output en, mode, si, seed_ld, seed,
        input  q, state, lockup, wrap, period
    );

    modport slave (
        input  en, mode, si, seed_ld, seed,
        output q, state, lockup, wrap, period
    );
endinterface

`default_nettype wire

// File: rtl/lfsr_period_mon.sv
// ============================================================================
// Module      : lfsr_period_mon
// Description : Measures the LFSR sequence period against a reference state
//               and pulses wrap when the sequence returns to it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_period_mon #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
    input  wire logic             clk,
    input  wire logic             arst_n,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    input  wire logic             shift,
    input  wire logic [WIDTH-1:0] shift_val,
    input  wire logic             adv,
    input  wire logic [WIDTH-1:0] next_state,
    output logic                  wrap,
    output logic [WIDTH-1:0]      period
);
    logic [WIDTH-1:0] r_ref;
    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + 1'b1;

    // Lock-up recovery cycles never assert adv, so they are neither counted
    // nor compared against the reference.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_ref    <= SEED;
            r_cnt    <= '0;
            r_wrap   <= 1'b0;
            r_period <= '0;
        end else begin
            r_wrap <= 1'b0;
            if (load) begin
                r_ref <= load_val;
                r_cnt <= '0;
            end else if (shift) begin
                r_ref <= shift_val;
                r_cnt <= '0;
            end else if (adv) begin
                if (next_state == r_ref) begin
                    r_wrap   <= 1'b1;
                    r_period <= w_cnt_inc;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign wrap   = r_wrap;
    assign period = r_period;

endmodule

`default_nettype wire

// File: rtl/lfsr_prbs_gen.sv
// ============================================================================
// Module      : lfsr_prbs_gen
// Description : Parametrised Fibonacci LFSR / PRBS generator with serial and
//               parallel seeding, additive scrambling and lock-up recovery.
//               Define LFSR_PERIOD_MON_EN to build in the period monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_prbs_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
    input  wire logic       clk,
    input  wire logic       arst_n,
    lfsr_prbs_gen_if.slave  bus
);
    logic [WIDTH-1:0] r_state;
    logic             r_lockup;
    logic             w_fb;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_shift_val;
    logic             w_is_zero;
    logic             w_shift;
    logic             w_run;
    logic             w_adv;

    assign w_fb        = ^(r_state & TAPS);
    assign w_next      = {r_state[WIDTH-2:0], w_fb};
    assign w_shift_val = {r_state[WIDTH-2:0], bus.si};
    assign w_is_zero   = (r_state == '0);

    // seed_ld overrides everything, so the mode qualifiers exclude it
    assign w_shift = !bus.seed_ld && bus.en && (bus.mode == MODE_SHIFT);
    assign w_run   = !bus.seed_ld && bus.en &&
                     ((bus.mode == MODE_RUN) || (bus.mode == MODE_SCRAMBLE));
    assign w_adv   = w_run && !w_is_zero;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state  <= SEED;
            r_lockup <= 1'b0;
        end else begin
            r_lockup <= 1'b0;
            if (bus.seed_ld) begin
                r_state <= bus.seed;
            end else if (w_shift) begin
                r_state <= w_shift_val;
            end else if (w_run) begin
                if (w_is_zero) begin
                    r_state  <= SEED;
                    r_lockup <= 1'b1;
                end else begin
                    r_state <= w_next;
                end
            end
        end
    end

    assign bus.q      = (bus.mode == MODE_SCRAMBLE) ? (bus.si ^ r_state[WIDTH-1])
                                                    : r_state[WIDTH-1];
    assign bus.state  = r_state;
    assign bus.lockup = r_lockup;

`ifdef LFSR_PERIOD_MON_EN
    lfsr_period_mon #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_period_mon (
        .clk        (clk),
        .arst_n     (arst_n),
        .load       (bus.seed_ld),
        .load_val   (bus.seed),
        .shift      (w_shift),
        .shift_val  (w_shift_val),
        .adv        (w_adv),
        .next_state (w_next),
        .wrap       (bus.wrap),
        .period     (bus.period)
    );
`else
    logic w_unused;
    assign w_unused   = w_adv;
    assign bus.wrap   = 1'b0;
    assign bus.period = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lfsr_prbs_gen.sv
// ============================================================================
// Module      : tb_lfsr_prbs_gen
// Description : Self-checking bench for lfsr_prbs_gen (WIDTH=4, taps 1100).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_prbs_gen;
    localparam int         W    = 4;
    localparam logic [3:0] TAPS = 4'b1100;
    localparam logic [3:0] SEED = 4'b0001;

    logic clk;
    logic arst_n;
    int   n_checks;
    int   n_errors;

    lfsr_prbs_gen_if #(.WIDTH(W)) bus ();

    lfsr_prbs_gen #(
        .WIDTH (W),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integers following the documented rules
    int m_state, m_ref, m_cnt, m_period, m_lock, m_wrap;

    function automatic int parity_next(input int s);
        int p;
        p = 0;
        for (int i = 0; i < W; i++)
            if (((TAPS >> i) & 1) != 0 && ((s >> i) & 1) != 0) p ^= 1;
        return ((s << 1) | p) % 16;
    endfunction

    task automatic model_reset();
        m_state = SEED; m_ref = SEED; m_cnt = 0; m_period = 0; m_lock = 0; m_wrap = 0;
    endtask

    task automatic model_step(input int en, input int mode, input int si, input int ld, input int seed);
        int nxt;
        m_lock = 0;
        m_wrap = 0;
        if (ld != 0) begin
            m_state = seed; m_ref = seed; m_cnt = 0;
        end else if (en != 0 && mode == 1) begin
            m_state = ((m_state << 1) | si) % 16;
            m_ref   = m_state;
            m_cnt   = 0;
        end else if (en != 0 && mode >= 2) begin
            if (m_state == 0) begin
                m_state = SEED; m_lock = 1;
            end else begin
                nxt = parity_next(m_state);
                if (nxt == m_ref) begin
                    m_wrap = 1; m_period = m_cnt + 1; m_cnt = 0;
                end else begin
                    m_cnt = (m_cnt + 1) % 16;
                end
                m_state = nxt;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_wrap();
`ifdef LFSR_PERIOD_MON_EN
        return m_wrap;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_period();
`ifdef LFSR_PERIOD_MON_EN
        return m_period;
`else
        return 0;
`endif
    endfunction

    task automatic compare_all(input string tag);
        int eq;
        eq = (bus.mode == 2'b11) ? (bus.si ^ ((m_state >> 3) & 1)) : ((m_state >> 3) & 1);
        chk({tag, ".state"},  int'(bus.state),  m_state);
        chk({tag, ".q"},      int'(bus.q),      eq);
        chk({tag, ".lockup"}, int'(bus.lockup), m_lock);
        chk({tag, ".wrap"},   int'(bus.wrap),   exp_wrap());
        chk({tag, ".period"}, int'(bus.period), exp_period());
    endtask

    task automatic apply(input int en, input int mode, input int si, input int ld, input int seed);
        bus.en      = en[0];
        bus.mode    = mode[1:0];
        bus.si      = si[0];
        bus.seed_ld = ld[0];
        bus.seed    = seed[3:0];
        model_step(en, mode, si, ld, seed);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int en; int mode; int si; int ld; int seed;
        int exp_state; int exp_lock;
    } vec_t;

    vec_t vecs[$];
    int   scr_q[4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        arst_n = 1'b0;
        bus.en = 1'b0; bus.mode = 2'b00; bus.si = 1'b0; bus.seed_ld = 1'b0; bus.seed = 4'h0;
        model_reset();
        #22;
        arst_n = 1'b1;
        #1;
        chk("reset.state",  int'(bus.state),  1);
        chk("reset.q",      int'(bus.q),      0);
        chk("reset.lockup", int'(bus.lockup), 0);
        chk("reset.wrap",   int'(bus.wrap),   0);
        chk("reset.period", int'(bus.period), 0);

        // {en, mode, si, ld, seed, expected state, expected lockup}
        vecs.push_back('{1, 2, 0, 0, 0, 4'b0010, 0});
        vecs.push_back('{1, 2, 0, 0, 0, 4'b0100, 0});
        vecs.push_back('{1, 2, 0, 0, 0, 4'b1001, 0});
        vecs.push_back('{0, 2, 0, 0, 0, 4'b1001, 0});
        vecs.push_back('{0, 2, 0, 0, 0, 4'b1001, 0});
        vecs.push_back('{1, 1, 1, 0, 0, 4'b0011, 0});
        vecs.push_back('{1, 1, 0, 0, 0, 4'b0110, 0});
        vecs.push_back('{1, 1, 1, 0, 0, 4'b1101, 0});
        vecs.push_back('{1, 1, 1, 0, 0, 4'b1011, 0});
        vecs.push_back('{1, 2, 0, 1, 6, 4'b0110, 0});
        vecs.push_back('{1, 2, 0, 1, 0, 4'b0000, 0});
        vecs.push_back('{1, 2, 0, 0, 0, 4'b0001, 1});
        vecs.push_back('{1, 2, 0, 0, 0, 4'b0010, 0});
        vecs.push_back('{1, 0, 1, 0, 0, 4'b0010, 0});
        vecs.push_back('{0, 1, 1, 0, 0, 4'b0010, 0});
        foreach (vecs[i]) begin
            apply(vecs[i].en, vecs[i].mode, vecs[i].si, vecs[i].ld, vecs[i].seed);
            chk($sformatf("vec%0d.state", i),  int'(bus.state),  vecs[i].exp_state);
            chk($sformatf("vec%0d.lockup", i), int'(bus.lockup), vecs[i].exp_lock);
            chk($sformatf("vec%0d.wrap", i),   int'(bus.wrap),   0);
            compare_all($sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-RUN takes effect before the next edge
        apply(1, 2, 0, 0, 0);
        apply(1, 2, 0, 0, 0);
        #2;
        arst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst.state", int'(bus.state), 1);
        @(negedge clk);
        arst_n = 1'b1;
        compare_all("async_rst");

        // Period measurement: wrap on the 15th advance, then again 15 later
        apply(0, 0, 0, 1, 1);
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 1; k <= 15; k++) begin
                apply(1, 2, 0, 0, 0);
`ifdef LFSR_PERIOD_MON_EN
                chk($sformatf("period.wrap%0d_%0d", rep, k), int'(bus.wrap), (k == 15) ? 1 : 0);
`else
                chk($sformatf("period.wrap%0d_%0d", rep, k), int'(bus.wrap), 0);
`endif
                if (k == 15) begin
                    chk("period.state", int'(bus.state), 1);
`ifdef LFSR_PERIOD_MON_EN
                    chk("period.value", int'(bus.period), 15);
`else
                    chk("period.value", int'(bus.period), 0);
`endif
                end
                compare_all("period");
            end
        end

        // Scrambler output with constant si=1 from state 0001
        scr_q = '{1, 1, 1, 0};
        apply(0, 0, 0, 1, 1);
        bus.mode = 2'b11;
        bus.si   = 1'b1;
        bus.en   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("scramble.q%0d", k), int'(bus.q), scr_q[k]);
            apply(1, 3, 1, 0, 0);
            compare_all("scramble");
        end

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            apply(($urandom_range(0, 3) != 0) ? 1 : 0,
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) == 0) ? 1 : 0,
                  int'($urandom_range(0, 15)));
            compare_all("random");
        end

        // Long RUN stretch so the period monitor sees full cycles
        apply(0, 0, 0, 1, 5);
        for (int n = 0; n < 40; n++) begin
            apply(1, 2 + int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 0, 0);
            compare_all("longrun");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/lfsr_prbs_gen.md
Name: lfsr_prbs_gen

Overview:
- Parametrised Fibonacci LFSR / PRBS generator. Replaces the fixed-width serial LFSR.
- Adds:
  - generic width and tap mask
  - parallel seed load
  - serial seed shift-in mode
  - run mode and additive-scrambler mode
  - all-zero lock-up recovery
  - optional period monitor
- Sits in front of serial links and test-pattern paths. Control comes from a local CSR block.

Parameters:
- WIDTH, 8, LFSR length in bits (min 3).
- TAPS, 8'hB8, feedback tap mask WIDTH bits wide. Bit i set means state[i] feeds the XOR. The default is maximal for WIDTH=8.
- SEED, 8'h01, reset and lock-up recovery state. Must be non-zero.

Ports:
- clk  in  1  system clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- en  in  1  advance enable; when 0, state holds (except seed_ld)
- mode  in  2  00 HOLD, 01 SHIFT (serial load), 10 RUN, 11 SCRAMBLE
- si  in  1  serial input: shift-in data in SHIFT, payload in SCRAMBLE
- seed_ld  in  1  parallel load strobe
- seed  in  WIDTH  parallel seed value
- q  out  1  serial output
- state  out  WIDTH  current register contents
- lockup  out  1  one-cycle pulse on all-zero recovery
- wrap  out  1  one-cycle pulse when the sequence returns to the reference state
- period  out  WIDTH  last measured sequence period

Behaviour:
- Reset: on arst_n low, asynchronously set state_r=SEED and ref_r=SEED. Set cnt_r, period, lockup and wrap to 0.
- Feedback: fb = ^(state_r & TAPS). Advance means state_r <= {state_r[WIDTH-2:0], fb}.
- Priority per rising edge: seed_ld > (en && mode) > hold.
- seed_ld=1 (regardless of en/mode):
  - state_r <= seed, ref_r <= seed, cnt_r <= 0.
  - A zero seed is loaded as-is; recovery happens on the next RUN/SCRAMBLE advance.
- HOLD: state holds even with en=1.
- SHIFT with en=1:
  - state_r <= {state_r[WIDTH-2:0], si}.
  - ref_r tracks the new state_r value; cnt_r <= 0.
- RUN and SCRAMBLE with en=1, state_r != 0: advance.
- RUN and SCRAMBLE with en=1, state_r == 0:
  - state_r <= SEED, lockup <= 1 for one cycle, cnt_r <= 0.
  - ref_r is unchanged; no wrap is generated.
- en=0: no state/ref/cnt change. lockup and wrap are 0 the next cycle.
- Output q is combinational from registers:
  - q = state_r[WIDTH-1] in HOLD/SHIFT/RUN.
  - q = si ^ state_r[WIDTH-1] in SCRAMBLE.
- The state output equals state_r; no extra latency.
- Mode change mid-operation takes effect on the same edge. Nothing is flushed and state is preserved.

Optional Feature:
- Macro: LFSR_PERIOD_MON_EN.
- When defined:
  - On each RUN/SCRAMBLE advance, compute next_state. If next_state == ref_r, then wrap <= 1 (one-cycle pulse), period <= cnt_r + 1 and cnt_r <= 0. Otherwise cnt_r <= cnt_r + 1, wrapping modulo 2^WIDTH.
  - A lock-up recovery cycle is not counted.
  - seed_ld or SHIFT clears cnt_r but leaves period unchanged.
- When undefined: cnt_r is not instantiated, and wrap and period are tied to 0.

Decomposition:
- Package lfsr_pkg holds:
  - the mode encoding constants MODE_HOLD/MODE_SHIFT/MODE_RUN/MODE_SCRAMBLE
  - the default tap-mask constants per common width (4, 7, 8, 15, 16, 23, 31)
- One natural sub-module, lfsr_period_mon. It holds ref_r, cnt_r, wrap and period, and is instantiated only under LFSR_PERIOD_MON_EN. The core keeps state and lock-up logic.

Test Plan (WIDTH=4, TAPS=4'b1100, SEED=4'b0001 unless stated):
- Reset then release -> state=0001, q=0, lockup=0, wrap=0, period=0. Hold arst_n low mid-RUN -> state returns to 0001 immediately, without waiting for a clock.
- RUN, en=1, 3 cycles from 0001 -> state sequence 0010, 0100, 1001. With en=0 for 2 cycles the state holds at 1001.
- SHIFT, en=1, si=1,0,1,1 -> state=1011. wrap=0 throughout and cnt cleared. Then seed_ld with seed=0110 and mode=RUN on the same edge -> state=0110 (load wins).
- seed_ld seed=0000, then RUN 1 cycle -> state=0001, lockup=1 for exactly 1 cycle, then 0.
- With LFSR_PERIOD_MON_EN, seed_ld 0001, then RUN 15 cycles -> wrap pulses on the 15th advance with state=0001 and period=15. It pulses again after 15 more cycles. Without the macro, wrap and period stay 0.
- SCRAMBLE with si=1 constant from 0001 -> q sequence 1,1,1,0 over 4 cycles (si ^ state[3]). State advances identically to RUN.
